// File: rtl/pipe_fetch_unit_if.sv
`timescale 1ns/1ps
// pipe_fetch_unit_if
//   Bundles every non-clock signal of the IF stage: the hazard/ID control
//   inputs, the instruction-memory request/response channel and the IF/ID
//   pipeline register outputs.
//   master : the fetch unit (drives imem_req/imem_addr and ifid_*)
//   slave  : the surroundings (hazard unit, ID stage, instruction memory)
interface pipe_fetch_unit_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;

  modport master (
    input  stall, redirect, redirect_pc,
    input  imem_ready, imem_rvalid, imem_rdata,
    output imem_req, imem_addr,
    output ifid_valid, ifid_instr, ifid_pc, ifid_pc4
  );

  modport slave (
    output stall, redirect, redirect_pc,
    output imem_ready, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr,
    input  ifid_valid, ifid_instr, ifid_pc, ifid_pc4
  );
endinterface

// File: rtl/pipe_fetch_unit.sv
`timescale 1ns/1ps
// pipe_fetch_unit
//   IF stage of the 5-stage MIPS pipeline. Owns the PC, keeps at most one
//   instruction-memory request outstanding and fills the IF/ID register.
//   Honours stall from the hazard unit and branch/jump redirects from ID so
//   that no instruction is ever lost or duplicated.
// Ports
//   clk   : single clock, all state changes on the rising edge
//   reset : asynchronous, active-high
//   bus   : pipe_fetch_unit_if.master
//           stall / redirect / redirect_pc         control from hazard unit and ID
//           imem_req / imem_addr / imem_ready      request channel
//           imem_rvalid / imem_rdata               response channel
//           ifid_valid / ifid_instr / ifid_pc(4)   IF/ID pipeline register
module pipe_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input logic               clk,
  input logic               reset,
  pipe_fetch_unit_if.master bus
);

  // FETCH: may issue a request. WAIT: request accepted, awaiting response.
  // HOLD: response parked in the buffer because ID is stalled.
  // DROP: a squashed request is still in flight; swallow its response.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } fetchState_t;

  fetchState_t r_state;
  fetchState_t w_nextState;

  logic [31:0] r_pc;
  logic        r_bufValid;
  logic [31:0] r_bufInstr;
  logic        r_ifidValid;
  logic [31:0] r_ifidInstr;
  logic [31:0] r_ifidPc;
  logic [31:0] r_ifidPc4;

  logic        w_req;
  logic        w_load;
  logic        w_capture;
  logic        w_release;
  logic [31:0] w_loadInstr;
  logic [31:0] w_pcPlus4;
  logic [31:0] w_redirectPc;

  // The PC always points at the word being fetched (or parked), so it only
  // advances when that word actually lands in IF/ID. Redirect targets are
  // forced word-aligned by masking the two low bits.
  assign w_pcPlus4    = r_pc + 32'd4;
  assign w_redirectPc = bus.redirect_pc & ~32'd3;
  assign w_req        = (r_state == ST_FETCH) && !bus.redirect && !reset;

  assign bus.imem_req   = w_req;
  assign bus.imem_addr  = r_pc;
  assign bus.ifid_valid = r_ifidValid;
  assign bus.ifid_instr = r_ifidInstr;
  assign bus.ifid_pc    = r_ifidPc;
  assign bus.ifid_pc4   = r_ifidPc4;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and datapath control. A redirect overrides everything else,
  // including a response arriving in the same cycle; a request that is still
  // in flight when the redirect hits is remembered by moving to DROP.
  // A response that arrives while ID is stalled on a valid instruction is
  // parked in the buffer instead of overwriting IF/ID.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    w_loadInstr = bus.imem_rdata;
    if (bus.redirect) begin
      case (r_state)
        ST_WAIT, ST_DROP: w_nextState = bus.imem_rvalid ? ST_FETCH : ST_DROP;
        default:          w_nextState = ST_FETCH;
      endcase
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_req && bus.imem_ready) begin
            w_nextState = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rvalid) begin
            if (bus.stall && r_ifidValid) begin
              w_capture   = 1'b1;
              w_nextState = ST_HOLD;
            end else begin
              w_load      = 1'b1;
              w_nextState = ST_FETCH;
            end
          end
        end
        ST_HOLD: begin
          if (!bus.stall) begin
            w_release   = 1'b1;
            w_load      = r_bufValid;
            w_loadInstr = r_bufInstr;
            w_nextState = ST_FETCH;
          end
        end
        ST_DROP: begin
          if (bus.imem_rvalid) begin
            w_nextState = ST_FETCH;
          end
        end
        default: w_nextState = ST_FETCH;
      endcase
    end
  end

  // PC, buffer and IF/ID register. Without a new instruction, a stalled ID
  // keeps IF/ID untouched while a running ID receives a bubble; the bubble
  // keeps the old pc/pc4 so only valid and instr change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_bufValid  <= 1'b0;
      r_bufInstr  <= NOP_INSTR;
      r_ifidValid <= 1'b0;
      r_ifidInstr <= NOP_INSTR;
      r_ifidPc    <= 32'h0;
      r_ifidPc4   <= 32'h0;
    end else if (bus.redirect) begin
      r_pc        <= w_redirectPc;
      r_bufValid  <= 1'b0;
      r_ifidValid <= 1'b0;
      r_ifidInstr <= NOP_INSTR;
    end else begin
      if (w_capture) begin
        r_bufValid <= 1'b1;
        r_bufInstr <= bus.imem_rdata;
      end else if (w_release) begin
        r_bufValid <= 1'b0;
      end
      if (w_load) begin
        r_pc        <= w_pcPlus4;
        r_ifidValid <= 1'b1;
        r_ifidInstr <= w_loadInstr;
        r_ifidPc    <= r_pc;
        r_ifidPc4   <= w_pcPlus4;
      end else if (!bus.stall) begin
        r_ifidValid <= 1'b0;
        r_ifidInstr <= NOP_INSTR;
      end
    end
  end

endmodule
